// File: rtl/onehot_pkg.sv
// Shared types and helpers for the one-hot ring sequence checker.
// The rotation helper works on a fixed 32-bit container so any ring width up to 32 can use it.
package onehot_pkg;

    typedef enum logic [1:0] {
        SEARCH,
        ACQUIRE,
        LOCKED
    } state_t;

    localparam int DEF_NBITS = 4;
    localparam int IDX_W     = $clog2(DEF_NBITS);
    localparam int ROT_MAX   = 32;

    // Rotate left by one within the low 'width' bits; the bit at width-1 wraps to bit 0.
    function automatic logic [ROT_MAX-1:0] rotl1(input logic [ROT_MAX-1:0] value,
                                                 input int                 width);
        logic [ROT_MAX-1:0] r;
        r = '0;
        for (int i = 1; i < ROT_MAX; i++) begin
            if (i < width) r[i] = value[i-1];
        end
        for (int i = 0; i < ROT_MAX; i++) begin
            if (i == width - 1) r[0] = value[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/onehot_seq_checker_decode.sv
// Combinational one-hot decoder: flags whether exactly one bit is set and reports its position.
module onehot_seq_checker_decode #(
    parameter int NBITS = 4
) (
    input  logic [NBITS-1:0]         din,
    output logic                     legal,
    output logic [$clog2(NBITS)-1:0] idx
);

    always_comb begin
        legal = (din != '0) && ((din & (din - NBITS'(1))) == '0);
        idx   = '0;
        for (int i = 0; i < NBITS; i++) begin
            if (din[i]) idx = ($clog2(NBITS))'(i);
        end
    end

endmodule

// File: rtl/onehot_seq_checker.sv
// Checks that a sampled one-hot word advances by one left rotation per valid sample.
// Optional sticky error flag with clear input when ONEHOT_CHK_STICKY_EN is defined.
module onehot_seq_checker
    import onehot_pkg::*;
#(
    parameter int NBITS    = DEF_NBITS,
    parameter int LOCK_CNT = 4,
    parameter int ERR_W    = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     din_valid,
    input  logic [NBITS-1:0]         din,
`ifdef ONEHOT_CHK_STICKY_EN
    input  logic                     err_clr,
    output logic                     err_sticky,
`endif
    output logic [$clog2(NBITS)-1:0] idx,
    output logic                     idx_valid,
    output logic                     locked,
    output logic                     seq_err,
    output logic                     wrap,
    output logic [ERR_W-1:0]         err_count
);

    localparam int IW    = $clog2(NBITS);
    localparam int CNT_W = 4;

    state_t             state, state_n;
    logic [NBITS-1:0]   last_code, last_code_n;
    logic [CNT_W-1:0]   step_cnt, step_cnt_n;
    logic [IW-1:0]      idx_n;
    logic               idx_valid_n, seq_err_n, wrap_n;
    logic [ERR_W-1:0]   err_count_n;
    logic               dec_legal;
    logic [IW-1:0]      dec_idx;
    logic [NBITS-1:0]   expected;
    logic               match;
`ifdef ONEHOT_CHK_STICKY_EN
    logic               err_sticky_n;
`endif

    onehot_seq_checker_decode #(.NBITS(NBITS)) u_decode (
        .din   (din),
        .legal (dec_legal),
        .idx   (dec_idx)
    );

    assign expected = NBITS'(rotl1(ROT_MAX'(last_code), NBITS));
    assign match    = dec_legal && (din == expected);
    assign locked   = (state == LOCKED);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= SEARCH;
            last_code  <= '0;
            step_cnt   <= '0;
            idx        <= '0;
            idx_valid  <= 1'b0;
            seq_err    <= 1'b0;
            wrap       <= 1'b0;
            err_count  <= '0;
`ifdef ONEHOT_CHK_STICKY_EN
            err_sticky <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            last_code  <= last_code_n;
            step_cnt   <= step_cnt_n;
            idx        <= idx_n;
            idx_valid  <= idx_valid_n;
            seq_err    <= seq_err_n;
            wrap       <= wrap_n;
            err_count  <= err_count_n;
`ifdef ONEHOT_CHK_STICKY_EN
            err_sticky <= err_sticky_n;
`endif
        end
    end

    always_comb begin
        state_n     = state;
        last_code_n = last_code;
        step_cnt_n  = step_cnt;
        idx_n       = idx;
        idx_valid_n = 1'b0;
        seq_err_n   = 1'b0;
        wrap_n      = 1'b0;

        if (din_valid) begin
            idx_valid_n = dec_legal;
            if (dec_legal) idx_n = dec_idx;

            unique case (state)
                SEARCH: begin
                    if (dec_legal) begin
                        last_code_n = din;
                        step_cnt_n  = CNT_W'(1);
                        state_n     = (LOCK_CNT == 1) ? LOCKED : ACQUIRE;
                    end
                end
                ACQUIRE: begin
                    if (match) begin
                        last_code_n = din;
                        step_cnt_n  = step_cnt + CNT_W'(1);
                        wrap_n      = last_code[NBITS-1];
                        if (step_cnt + CNT_W'(1) >= CNT_W'(LOCK_CNT)) state_n = LOCKED;
                    end else if (dec_legal) begin
                        // A repeated or skipped code restarts acquisition from this sample.
                        last_code_n = din;
                        step_cnt_n  = CNT_W'(1);
                    end else begin
                        state_n    = SEARCH;
                        step_cnt_n = '0;
                    end
                end
                LOCKED: begin
                    if (match) begin
                        last_code_n = din;
                        wrap_n      = last_code[NBITS-1];
                    end else begin
                        seq_err_n  = 1'b1;
                        state_n    = SEARCH;
                        step_cnt_n = '0;
                    end
                end
                default: begin
                    state_n    = SEARCH;
                    step_cnt_n = '0;
                end
            endcase
        end
    end

    // Clearing zeroes the count first, so an error in the same cycle leaves a count of one.
    always_comb begin
        err_count_n = err_count;
`ifdef ONEHOT_CHK_STICKY_EN
        if (err_clr) err_count_n = '0;
        err_sticky_n = seq_err_n ? 1'b1 : (err_clr ? 1'b0 : err_sticky);
`endif
        if (seq_err_n && (err_count_n != {ERR_W{1'b1}})) err_count_n = err_count_n + ERR_W'(1);
    end

endmodule

// File: doc/onehot_seq_checker.md
Name: onehot_seq_checker

Overview:
- Receive-side counterpart of the team's 4-bit one-hot ring generator (sequence 0001 -> 0010 -> 0100 -> 1000 -> 0001).
- Samples the generator's output word, decodes each one-hot code to a binary index and checks that every step is a legal left rotation.
- Tracks lock status through an FSM and counts sequence errors.
- Sits downstream of the generator in lab datapaths, or as a bench-side monitor.

Parameters:
- NBITS, 4, width of the one-hot word.
- LOCK_CNT, 4, consecutive correct steps required to declare lock (range 1..15).
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- din_valid  input  1  din is sampled this cycle.
- din  input  NBITS  one-hot word from the generator.
- idx  output  $clog2(NBITS)  binary position of the set bit in the last valid sample.
- idx_valid  output  1  idx is updated and legal this cycle (1-cycle pulse).
- locked  output  1  FSM is in LOCKED.
- seq_err  output  1  1-cycle pulse on a detected error.
- wrap  output  1  1-cycle pulse when a legal 1000 -> 0001 step is accepted.
- err_count  output  ERR_W  saturating count of seq_err pulses.

Behaviour:
- Reset is synchronous, active-high; clock is clk. Reset is checked only on posedge clk.
- Reset values: idx=0, idx_valid=0, locked=0, seq_err=0, wrap=0, err_count=0; FSM=SEARCH; expected register cleared.
- All outputs are registered. Response appears on the clock edge that samples din_valid=1, so it is visible in the following cycle (1-cycle latency).
- din_valid=0: no check is made, FSM and counters hold, and all pulses (idx_valid, seq_err, wrap) are 0.
- Legal code: exactly one bit set. 0000 and multi-hot words are illegal.
- Expected next code = rotate-left of the last legal code (MSB wraps to bit 0).
- FSM:
  - SEARCH: legal code -> store it as last, set step count=1, go ACQUIRE (or LOCKED if LOCK_CNT=1). Illegal code -> stay in SEARCH, no seq_err (still hunting).
  - ACQUIRE: code equals expected -> step count+1, update last; when count reaches LOCK_CNT -> LOCKED. Legal but unexpected code -> restart with count=1 from this code, no seq_err. Illegal code -> SEARCH, no seq_err.
  - LOCKED: code equals expected -> stay. Any other code (illegal, or legal but wrong) -> seq_err=1, err_count+1, go SEARCH; the same sample is not reused for acquisition.
- idx_valid=1 on any sample where din is legal, in every state; idx updates only then and holds otherwise.
- wrap pulses only in ACQUIRE or LOCKED, on an accepted 1000 -> 0001 step.
- err_count saturates at 2^ERR_W-1 and does not wrap.
- Repeated identical code (e.g. generator stalled by a held parallel load, 0001 0001) counts as an unexpected step: an error in LOCKED, a restart in ACQUIRE.
- Reset mid-operation clears everything on that edge regardless of din_valid.

Optional Feature:
- Macro ONEHOT_CHK_STICKY_EN.
- Defined: adds input err_clr (1 bit) and output err_sticky (1 bit). err_sticky is set on any seq_err and held until err_clr=1 or reset. If err_clr and a new error occur in the same cycle, set wins. err_clr also zeroes err_count.
- Undefined: neither port exists and err_count clears only on reset.

Decomposition:
- Shared package onehot_pkg holds:
  - the state enum typedef (SEARCH, ACQUIRE, LOCKED);
  - localparam IDX_W = $clog2(NBITS) default;
  - function rotl1 (rotate-left by one).
- One natural sub-module: onehot_decode, purely combinational, din -> {legal, idx}. The FSM, counters and registers stay in the top module.

Test Plan:
- Reset, then din_valid=1 with 0001, 0010, 0100, 1000 -> locked=1 in the cycle after the 4th sample; idx sequence 0,1,2,3; err_count=0.
- While locked, continue with 0001 -> wrap=1 for one cycle, idx=0, locked stays 1.
- While locked, inject 0110 -> seq_err=1 for one cycle, locked=0, err_count=1, idx holds. Then 0100, 1000, 0001, 0010 -> relocks after the 4th sample.
- While locked, inject 0010 0010 (repeat) -> seq_err pulse and err_count increments; din_valid=0 gaps between legal steps cause no error.
- Force 2^ERR_W+3 errors -> err_count stops at 255. Assert reset while locked -> all outputs 0 on the next cycle.
- With ONEHOT_CHK_STICKY_EN defined: an error sets err_sticky; err_clr=1 clears err_sticky and err_count; err_clr together with a new error leaves err_sticky=1.
